// File: rtl/fetch_pc_stage_if.sv
// rtl/fetch_pc_stage_if.sv - fetch stage bus: redirect/stall in, IMEM address/data, IF outputs to decode
interface fetch_pc_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] fetch_addr;
    logic [31:0] inst_in;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_target, inst_in,
        output fetch_addr, if_pc, if_inst, if_valid, misalign_err, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_target, inst_in,
        input  fetch_addr, if_pc, if_inst, if_valid, misalign_err, fetch_count
    );
endinterface

// File: rtl/fetch_pc_stage.sv
// rtl/fetch_pc_stage.sv - Riscv151 IF stage: PC, boot/stall/redirect sequencing for 1-cycle IMEM
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    fetch_pc_stage_if.master  bus
);
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;
    logic [31:0] tgt;

    assign tgt = {bus.redirect_target[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    // BOOT lasts exactly one edge regardless of stall/redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        bus.if_valid = (state_q == RUN) && !bus.redirect_valid;
        if (rst)
            bus.fetch_addr = RESET_PC;
        else if (bus.redirect_valid)
            bus.fetch_addr = tgt;
        else if (bus.stall || state_q == BOOT)
            bus.fetch_addr = pc_q;
        else
            bus.fetch_addr = pc_q + 32'd4;
        bus.if_pc        = pc_q;
        bus.if_inst      = bus.if_valid ? bus.inst_in : NOP_INST;
        bus.misalign_err = misalign_q;
        bus.fetch_count  = count_q;
    end

    // Registering the presented address keeps pc_q aligned with next cycle's inst_in.
    always_comb begin
        pc_d       = bus.fetch_addr;
        misalign_d = misalign_q |
                     (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00));
        count_d    = count_q + {31'd0, (bus.if_valid && !bus.stall)};
    end
endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb/tb_fetch_pc_stage.sv - directed bench for fetch_pc_stage
module tb_fetch_pc_stage;
    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fetch_pc_stage_if fif ();

    fetch_pc_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (fif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word i holds 32'h100+i, i counted in words from RESET_PC.
    always @(posedge clk)
        fif.inst_in <= 32'h100 + ((fif.fetch_addr - RST_PC) >> 2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (fif.if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %h want 0", fif.if_valid); end
        n_cmp++; if (fif.if_pc !== RST_PC) begin n_err++; $display("FAIL rst_pc got %h want %h", fif.if_pc, RST_PC); end
        n_cmp++; if (fif.if_inst !== NOP) begin n_err++; $display("FAIL rst_inst got %h want %h", fif.if_inst, NOP); end
        n_cmp++; if (fif.fetch_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr got %h want %h", fif.fetch_addr, RST_PC); end
        n_cmp++; if (fif.misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_mis got %h want 0", fif.misalign_err); end
        n_cmp++; if (fif.fetch_count !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %h want 0", fif.fetch_count); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (fif.if_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid got %h want 0", fif.if_valid); end
        n_cmp++; if (fif.fetch_addr !== RST_PC) begin n_err++; $display("FAIL boot_addr got %h want %h", fif.fetch_addr, RST_PC); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_pc = RST_PC + 32'(4 * i);
            n_cmp++; if (fif.if_valid !== 1'b1) begin n_err++; $display("FAIL run_valid[%0d] got %h want 1", i, fif.if_valid); end
            n_cmp++; if (fif.if_pc !== exp_pc) begin n_err++; $display("FAIL run_pc[%0d] got %h want %h", i, fif.if_pc, exp_pc); end
            n_cmp++; if (fif.if_inst !== 32'(32'h100 + i)) begin n_err++; $display("FAIL run_inst[%0d] got %h want %h", i, fif.if_inst, 32'h100 + i); end
            n_cmp++; if (fif.fetch_count !== 32'(i)) begin n_err++; $display("FAIL run_cnt[%0d] got %0d want %0d", i, fif.fetch_count, i); end
        end
    endtask

    task automatic test_stall();
        tick();
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (fif.fetch_addr !== 32'h4000_0008) begin n_err++; $display("FAIL stall_addr[%0d] got %h want 40000008", i, fif.fetch_addr); end
            n_cmp++; if (fif.if_pc !== 32'h4000_0008) begin n_err++; $display("FAIL stall_pc[%0d] got %h want 40000008", i, fif.if_pc); end
            n_cmp++; if (fif.if_inst !== 32'h102) begin n_err++; $display("FAIL stall_inst[%0d] got %h want 102", i, fif.if_inst); end
            n_cmp++; if (fif.fetch_count !== 32'd2) begin n_err++; $display("FAIL stall_cnt[%0d] got %0d want 2", i, fif.fetch_count); end
            tick();
        end
        fif.stall = 1'b0;
        #1;
        n_cmp++; if (fif.if_pc !== 32'h4000_0008) begin n_err++; $display("FAIL unstall_pc got %h want 40000008", fif.if_pc); end
        tick();
        n_cmp++; if (fif.if_pc !== 32'h4000_000C) begin n_err++; $display("FAIL resume_pc got %h want 4000000c", fif.if_pc); end
        n_cmp++; if (fif.if_inst !== 32'h103) begin n_err++; $display("FAIL resume_inst got %h want 103", fif.if_inst); end
        n_cmp++; if (fif.fetch_count !== 32'd3) begin n_err++; $display("FAIL resume_cnt got %0d want 3", fif.fetch_count); end
    endtask

    task automatic test_redirect();
        tick();
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'h4000_0040;
        #1;
        n_cmp++; if (fif.if_pc !== 32'h4000_0010) begin n_err++; $display("FAIL redir_cur_pc got %h want 40000010", fif.if_pc); end
        n_cmp++; if (fif.if_valid !== 1'b0) begin n_err++; $display("FAIL redir_kill got %h want 0", fif.if_valid); end
        n_cmp++; if (fif.if_inst !== NOP) begin n_err++; $display("FAIL redir_nop got %h want %h", fif.if_inst, NOP); end
        n_cmp++; if (fif.fetch_addr !== 32'h4000_0040) begin n_err++; $display("FAIL redir_addr got %h want 40000040", fif.fetch_addr); end
        tick();
        fif.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (fif.if_pc !== 32'h4000_0040) begin n_err++; $display("FAIL redir_pc got %h want 40000040", fif.if_pc); end
        n_cmp++; if (fif.if_valid !== 1'b1) begin n_err++; $display("FAIL redir_valid got %h want 1", fif.if_valid); end
        n_cmp++; if (fif.if_inst !== 32'h110) begin n_err++; $display("FAIL redir_inst got %h want 110", fif.if_inst); end
        n_cmp++; if (fif.fetch_count !== 32'd4) begin n_err++; $display("FAIL redir_cnt got %0d want 4", fif.fetch_count); end
    endtask

    task automatic test_redirect_with_stall();
        tick();
        fif.redirect_valid  = 1'b1;
        fif.stall           = 1'b1;
        fif.redirect_target = 32'h4000_0080;
        #1;
        n_cmp++; if (fif.fetch_addr !== 32'h4000_0080) begin n_err++; $display("FAIL rs_addr got %h want 40000080", fif.fetch_addr); end
        n_cmp++; if (fif.if_valid !== 1'b0) begin n_err++; $display("FAIL rs_kill got %h want 0", fif.if_valid); end
        tick();
        fif.redirect_valid = 1'b0;
        fif.stall          = 1'b0;
        #1;
        n_cmp++; if (fif.if_pc !== 32'h4000_0080) begin n_err++; $display("FAIL rs_pc got %h want 40000080", fif.if_pc); end
        n_cmp++; if (fif.if_inst !== 32'h120) begin n_err++; $display("FAIL rs_inst got %h want 120", fif.if_inst); end
        n_cmp++; if (fif.fetch_count !== 32'd5) begin n_err++; $display("FAIL rs_cnt got %0d want 5", fif.fetch_count); end
    endtask

    task automatic test_misalign();
        tick();
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'h4000_0022;
        #1;
        n_cmp++; if (fif.fetch_addr !== 32'h4000_0020) begin n_err++; $display("FAIL mis_addr got %h want 40000020", fif.fetch_addr); end
        n_cmp++; if (fif.misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_pre got %h want 0", fif.misalign_err); end
        tick();
        fif.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (fif.if_pc !== 32'h4000_0020) begin n_err++; $display("FAIL mis_pc got %h want 40000020", fif.if_pc); end
        n_cmp++; if (fif.if_inst !== 32'h108) begin n_err++; $display("FAIL mis_inst got %h want 108", fif.if_inst); end
        n_cmp++; if (fif.misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_set got %h want 1", fif.misalign_err); end
    endtask

    task automatic test_back_to_back();
        tick();
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'h4000_0100;
        #1;
        n_cmp++; if (fif.if_valid !== 1'b0) begin n_err++; $display("FAIL b2b_kill0 got %h want 0", fif.if_valid); end
        tick();
        fif.redirect_target = 32'h4000_0200;
        #1;
        n_cmp++; if (fif.if_pc !== 32'h4000_0100) begin n_err++; $display("FAIL b2b_pc0 got %h want 40000100", fif.if_pc); end
        n_cmp++; if (fif.if_valid !== 1'b0) begin n_err++; $display("FAIL b2b_kill1 got %h want 0", fif.if_valid); end
        tick();
        fif.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (fif.if_pc !== 32'h4000_0200) begin n_err++; $display("FAIL b2b_pc1 got %h want 40000200", fif.if_pc); end
        n_cmp++; if (fif.if_inst !== 32'h180) begin n_err++; $display("FAIL b2b_inst got %h want 180", fif.if_inst); end
        n_cmp++; if (fif.misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky got %h want 1", fif.misalign_err); end
        n_cmp++; if (fif.fetch_count !== 32'd7) begin n_err++; $display("FAIL b2b_cnt got %0d want 7", fif.fetch_count); end
    endtask

    task automatic test_wrap();
        tick();
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'hFFFF_FFFC;
        tick();
        fif.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (fif.if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got %h want fffffffc", fif.if_pc); end
        n_cmp++; if (fif.fetch_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h want 0", fif.fetch_addr); end
        tick();
        n_cmp++; if (fif.if_pc !== 32'h0) begin n_err++; $display("FAIL wrap_next got %h want 0", fif.if_pc); end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (fif.if_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %h want 0", fif.if_valid); end
        n_cmp++; if (fif.if_pc !== RST_PC) begin n_err++; $display("FAIL ar_pc got %h want %h", fif.if_pc, RST_PC); end
        n_cmp++; if (fif.if_inst !== NOP) begin n_err++; $display("FAIL ar_inst got %h want %h", fif.if_inst, NOP); end
        n_cmp++; if (fif.fetch_addr !== RST_PC) begin n_err++; $display("FAIL ar_addr got %h want %h", fif.fetch_addr, RST_PC); end
        n_cmp++; if (fif.misalign_err !== 1'b0) begin n_err++; $display("FAIL ar_mis got %h want 0", fif.misalign_err); end
        n_cmp++; if (fif.fetch_count !== 32'd0) begin n_err++; $display("FAIL ar_cnt got %h want 0", fif.fetch_count); end
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (fif.if_valid !== 1'b0) begin n_err++; $display("FAIL ar_boot got %h want 0", fif.if_valid); end
        tick();
        n_cmp++; if (fif.if_pc !== RST_PC) begin n_err++; $display("FAIL ar_first_pc got %h want %h", fif.if_pc, RST_PC); end
        n_cmp++; if (fif.if_valid !== 1'b1) begin n_err++; $display("FAIL ar_first_valid got %h want 1", fif.if_valid); end
        n_cmp++; if (fif.if_inst !== 32'h100) begin n_err++; $display("FAIL ar_first_inst got %h want 100", fif.if_inst); end
        tick();
        n_cmp++; if (fif.if_pc !== 32'h4000_0004) begin n_err++; $display("FAIL ar_second_pc got %h want 40000004", fif.if_pc); end
        n_cmp++; if (fif.fetch_count !== 32'd1) begin n_err++; $display("FAIL ar_cnt_restart got %0d want 1", fif.fetch_count); end
    endtask

    initial begin
        n_cmp               = 0;
        n_err               = 0;
        rst                 = 1'b1;
        fif.stall           = 1'b0;
        fif.redirect_valid  = 1'b0;
        fif.redirect_target = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_with_stall();
        test_misalign();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Instruction-fetch stage of the Riscv151 pipeline: owns the program counter, drives the next-fetch address into the synchronous-read BIOS/IMEM, and presents each fetched instruction with its PC and a valid bit to decode. It consumes the taken-branch/jump redirect from the execute stage, where branch compare and target add happen. Because the memories have 1-cycle read latency, it also sequences boot, stalls and wrong-path kill.

## Interface
- RESET_PC, 32'h4000_0000, first instruction address after reset (BIOS base)
- NOP_INST, 32'h0000_0013, instruction presented when if_valid=0 (addi x0,x0,0)

- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  reset, asynchronous and active-high
- stall  in  1  decode/execute hazard; hold the PC and re-present the same instruction
- redirect_valid  in  1  taken branch or jump resolved this cycle
- redirect_target  in  32  target PC for redirect
- fetch_addr  out  32  byte address presented to instruction memories this cycle (combinational)
- inst_in  in  32  memory read data for the address presented on the previous cycle
- if_pc  out  32  PC of instruction on if_inst
- if_inst  out  32  fetched instruction, or NOP_INST when invalid
- if_valid  out  1  if_inst/if_pc are a real, on-path instruction
- misalign_err  out  1  sticky: a redirect target had [1:0]!=0
- fetch_count  out  32  number of instructions accepted by decode

## Operation
- Registers: pc_q (32), state (BOOT/RUN), misalign_err, fetch_count.
- Effective target tgt = {redirect_target[31:2],2'b00}.
- fetch_addr priority: rst -> RESET_PC; redirect_valid -> tgt; stall or state==BOOT -> pc_q; else pc_q+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
- pc_q <= fetch_addr every cycle, so inst_in on the next cycle always corresponds to pc_q.
- if_pc = pc_q always. if_inst = if_valid ? inst_in : NOP_INST.
- if_valid = (state==RUN) & ~redirect_valid. The redirect kills the wrong-path instruction currently in IF combinationally; older stages are flushed by the execute stage, not here.
- BOOT: entered on reset; if_valid=0 (memory output during and immediately after reset is untrusted); PC re-reads RESET_PC. Unconditional transition to RUN on the next edge, including when stall or redirect is asserted. A redirect in BOOT still loads tgt.
- RUN: stays RUN; only rst returns to BOOT.
- Stall: pc_q unchanged and fetch_addr=pc_q. The memory re-reads, so if_inst stays stable while inst_in is held by address.
- Redirect with stall: redirect wins; stall ignored that cycle.
- misalign_err: set on any edge with redirect_valid & (redirect_target[1:0]!=0); cleared only by rst.
- fetch_count: increments when if_valid & ~stall; wraps 0xFFFF_FFFF -> 0.

## Timing
- Reset (asynchronous, immediate): pc_q=RESET_PC, state=BOOT, if_valid=0, if_pc=RESET_PC, if_inst=NOP_INST, fetch_addr=RESET_PC, misalign_err=0, fetch_count=0.
- Reset asserted mid-run: all of the above take effect immediately, regardless of the clock; any in-flight redirect is lost.
- First valid instruction: the first edge after rst deasserts is the BOOT edge. The next cycle has if_valid=1 with if_pc=RESET_PC.
- Sequential throughput: 1 instruction per cycle with no stall.
- Redirect in cycle t: fetch_addr=tgt in cycle t and if_valid=0 in cycle t. In cycle t+1, if_pc=tgt, if_inst=mem[tgt] and if_valid=1 (unless a new redirect arrives). Branch penalty attributable to this stage is 1 killed slot.
- Back-to-back redirects: each cycle's target takes effect; if_valid=0 in every redirect cycle.

## Test plan
- Reset then free-run with memory word i = 32'h100+i: if_valid=0 for the BOOT cycle; then if_pc = 0x4000_0000, 0x4000_0004, 0x4000_0008 on consecutive cycles with matching if_inst; fetch_count=3 after 3 valid cycles.
- Stall for 3 cycles at if_pc=0x4000_0008: fetch_addr=0x4000_0008, and if_pc/if_inst are unchanged for 3 cycles; fetch_count does not increment; the run resumes at 0x4000_000C.
- Redirect to 0x4000_0040 while at 0x4000_0010: if_valid=0 that cycle; next cycle if_pc=0x4000_0040, if_valid=1; the instruction at 0x4000_0014 is never valid.
- Redirect and stall together with target 0x4000_0080: redirect wins; next if_pc=0x4000_0080.
- Redirect to 0x4000_0022: fetch proceeds from 0x4000_0020; misalign_err=1 and stays 1 until rst.
- Async rst pulse mid-run (not clock-aligned): outputs return to reset values immediately; after release, BOOT cycle then if_pc=0x4000_0000, and fetch_count restarts from 0.
